// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Two-client (A/B) req/gnt front end for one synchronous RAM port,
//            with fixed-latency read data returned to the issuing client.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    output logic                  ram_cen,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    logic                  r_prefer_b;
    logic [1:0]            r_rd_pend;
    logic [1:0]            r_rd_own_b;

    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_xfer;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // r_prefer_b is set once A has been served, so B wins the next tie.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            if (req_a && (!req_b || c_fixed_prio || !r_prefer_b)) begin
                w_gnt_a = 1'b1;
            end else if (req_b) begin
                w_gnt_b = 1'b1;
            end
        end
    end

    assign gnt_a       = w_gnt_a;
    assign gnt_b       = w_gnt_b;
    assign w_xfer      = w_gnt_a | w_gnt_b;
    assign w_sel_we    = w_gnt_b ? we_b    : we_a;
    assign w_sel_addr  = w_gnt_b ? addr_b  : addr_a;
    assign w_sel_wdata = w_gnt_b ? wdata_b : wdata_a;

    // Stage 1 of the read pipe lines up with the RAM access, stage 2 with ram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prefer_b <= 1'b0;
            ram_cen    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            r_rd_pend  <= '0;
            r_rd_own_b <= '0;
            rvalid_a   <= 1'b0;
            rvalid_b   <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            ram_cen <= w_xfer;
            ram_we  <= w_xfer & w_sel_we;
            if (w_xfer) begin
                ram_addr   <= w_sel_addr;
                ram_data   <= w_sel_wdata;
                r_prefer_b <= w_gnt_a;
            end
            r_rd_pend  <= {r_rd_pend[0], w_xfer & ~w_sel_we};
            r_rd_own_b <= {r_rd_own_b[0], w_gnt_b};
            rvalid_a   <= r_rd_pend[1] & ~r_rd_own_b[1];
            rvalid_b   <= r_rd_pend[1] &  r_rd_own_b[1];
            if (r_rd_pend[1] && !r_rd_own_b[1]) begin
                rdata_a <= ram_q;
            end
            if (r_rd_pend[1] && r_rd_own_b[1]) begin
                rdata_b <= ram_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Initiator-side front end for one port of the team's single-clock synchronous RAM: cen/we/address/data out, registered Q back with one cycle of read latency.
- Merges two clients onto that port: A (e.g. CPU) and B (e.g. video/DMA).
- Clients use a req/gnt handshake; read data comes back tagged to the issuing client with fixed latency.
- Instantiated beside each shared RAM port; the RAM itself is not part of this block.

Parameters:
DATA_WIDTH, 8, data width of clients and RAM port
ADDR_WIDTH, 10, address width of clients and RAM port
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
req_a  in  1  client A request
we_a  in  1  client A write (1) / read (0), qualified by req_a
addr_a  in  ADDR_WIDTH  client A address
wdata_a  in  DATA_WIDTH  client A write data
gnt_a  out  1  combinational grant; transfer when req_a&gnt_a at posedge
rvalid_a  out  1  one-cycle read-data strobe for A
rdata_a  out  DATA_WIDTH  read data for A
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for client B
ram_cen  out  1  RAM clock enable (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  ADDR_WIDTH  RAM address (registered)
ram_data  out  DATA_WIDTH  RAM write data (registered)
ram_q  in  DATA_WIDTH  RAM registered read output

Behaviour:
- Reset (synchronous): ram_cen, ram_we, ram_addr, ram_data = 0; rvalid_a/b = 0; rdata_a/b = 0; read pipeline cleared; round-robin pointer = "A preferred". gnt_a/b = 0 while reset is high.
- Arbitration (combinational, one winner per cycle):
  - Only one requester: it is granted.
  - Both requesting, FIXED_PRIO=1: A granted.
  - Both requesting, FIXED_PRIO=0: the client not served last is granted.
  - Pointer updates only on an actual transfer.
  - gnt never asserts without the matching req.
- Transfer at posedge t (req&gnt): the winner's we/addr/wdata are registered into ram_we/ram_addr/ram_data with ram_cen=1, visible during cycle t+1.
- Any cycle with no transfer: ram_cen=0, ram_we=0; ram_addr/ram_data hold their previous values.
- Clients may keep req high for back-to-back transfers: one transfer per cycle, 100% port utilisation.
- Read return:
  - RAM samples at posedge t+1; ram_q is valid in cycle t+2.
  - Block registers ram_q into rdata_<owner> at posedge t+2 and pulses rvalid_<owner> during cycle t+2 (registered strobe, 2 cycles after transfer edge).
  - Owner tracking: 2-stage shift register of {valid, is_read, owner}, advanced every cycle.
- Writes produce no rvalid.
- rdata_x holds its last value when rvalid_x is low.
- rvalid_a and rvalid_b are never high in the same cycle.
- Interleaved A/B reads return in issue order, each to its owner.
- Read-after-write to the same address in consecutive transfers returns the newly written data, since the RAM applies the write one cycle before the read.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset) and the pending RAM access is cancelled (ram_cen low the cycle after reset).
- Client inputs are sampled only at the transfer edge; after that they may change freely.

Test Plan:
- Single A write addr 0x005 data 0xA5, then A read 0x005 -> ram_cen/ram_we=1/1 then 1/0 on successive cycles; rvalid_a pulses 2 cycles after the read transfer with rdata_a=0xA5; rvalid_b never asserts.
- Both clients read continuously (A addr 0x010=0x11, B addr 0x020=0x22), FIXED_PRIO=0 -> gnt alternates A,B,A,B; rvalid alternates A,B with rdata_a=0x11 and rdata_b=0x22; no idle RAM cycles.
- Same stimulus with FIXED_PRIO=1 -> gnt_a high every cycle, gnt_b stays 0 until req_a drops; B's read is then granted on the first cycle without req_a.
- Back-to-back B write 0x3FF=0x5A then B read 0x3FF -> rdata_b=0x5A; address 0x3FF exercises the top address bit at ADDR_WIDTH=10.
- A read issued, reset asserted for one cycle at t+1 -> no rvalid_a in cycles t+2..t+4; all RAM outputs 0 after the reset edge; first post-reset A/B contention goes to A.
- Idle (no requests) for 8 cycles -> ram_cen=0 throughout; rdata_a/b hold their previous values.
